// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types and burst constants for the cache miss request controller
package cc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } cc_miss_state_t;

    // One cache line is fetched as an 8-beat x 8-byte wrap burst.
    localparam logic [3:0] CC_BURST_LEN     = 4'd7;
    localparam logic [2:0] CC_BURST_SIZE    = 3'd3;
    localparam logic [1:0] CC_BURST_WRAP    = 2'b10;
    localparam int         CC_LINE_OFFSET_W = 6;

endpackage

// File: rtl/cc_miss_req_ctrl_if.sv
// rtl/cc_miss_req_ctrl_if.sv - AXI AR channel plus monitored R handshake between controller and memory
//
// master : cache miss controller (drives AR, observes R handshake)
// slave  : memory side (drives arready and the R handshake signals)
interface cc_miss_req_ctrl_if;
    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;

    modport master (
        output mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        input  mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i
    );

    modport slave (
        input  mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        output mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i
    );
endinterface

// File: rtl/cc_credit_counter.sv
// rtl/cc_credit_counter.sv - saturating up/down in-flight burst counter with sticky underflow flag
//
// clk, rst  : clock, synchronous active-high reset
// inc       : a new burst is committed
// dec       : a burst completed (RLAST beat)
// count     : current in-flight count, never above MAX_OUTSTANDING
// underflow : sticky, set when a completion arrives with count == 0
module cc_credit_counter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            underflow <= 1'b0;
        end else if (dec && count == '0) begin
            // A spurious completion is flagged and otherwise ignored.
            underflow <= 1'b1;
            if (inc && count < MAX_CNT) begin
                count <= count + 1'b1;
            end
        end else if (inc && !dec && count < MAX_CNT) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/cc_miss_req_ctrl.sv
// rtl/cc_miss_req_ctrl.sv - accepts cache misses, pushes the miss FIFO and issues one wrap burst per miss
//
// clk, rst               : clock, synchronous active-high reset
// miss_req_*             : miss request handshake from the lookup stage
// mem                    : AXI AR channel and monitored R handshake (master modport)
// miss_addr_fifo_*       : push side of the miss-address FIFO
// outstanding_o          : bursts issued whose RLAST has not been seen
// err_o                  : sticky, RLAST completion seen with nothing outstanding
module cc_miss_req_ctrl
    import cc_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_req_valid_i,
    input  logic [31:0]          miss_req_addr_i,
    output logic                 miss_req_ready_o,
    cc_miss_req_ctrl_if.master   mem,
    input  logic                 miss_addr_fifo_full_i,
    output logic                 miss_addr_fifo_wren_o,
    output logic [31:0]          miss_addr_fifo_wdata_o,
    output logic [CNT_W-1:0]     outstanding_o,
    output logic                 err_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    cc_miss_state_t state;
    logic           ar_valid_q;
    logic [31:0]    ar_addr_q;
    logic           accept;
    logic           completion;

    // Credit is taken at accept using the registered count, so a completion
    // in the same cycle only frees credit from the following cycle.
    assign miss_req_ready_o = (state == IDLE) && (outstanding_o < MAX_CNT) && !miss_addr_fifo_full_i;
    assign accept           = miss_req_valid_i && miss_req_ready_o;
    assign completion       = mem.mem_rvalid_i && mem.mem_rready_i && mem.mem_rlast_i;

    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = accept ? miss_req_addr_i : 32'd0;

    assign mem.mem_arvalid_o = ar_valid_q;
    assign mem.mem_araddr_o  = ar_addr_q;
    assign mem.mem_arlen_o   = CC_BURST_LEN;
    assign mem.mem_arsize_o  = CC_BURST_SIZE;
    assign mem.mem_arburst_o = CC_BURST_WRAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        ar_valid_q <= 1'b1;
                        // Beat-aligned start address; the wrap burst returns
                        // the critical word first.
                        ar_addr_q  <= {miss_req_addr_i[31:3], 3'b000};
                    end
                end
                ISSUE: begin
                    if (mem.mem_arready_i) begin
                        state      <= IDLE;
                        ar_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ar_valid_q <= 1'b0;
                end
            endcase
        end
    end

    cc_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (accept),
        .dec       (completion),
        .count     (outstanding_o),
        .underflow (err_o)
    );
endmodule
